// File: rtl/sr_timer_bank_pkg.sv
// Shared types and register field positions for the sr_timer_bank timer bank.
package sr_timer_bank_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic {ONESHOT, PERIODIC} mode_t;

    localparam int CTL_SEL_LSB   = 0;
    localparam int CTL_SEL_W     = 4;
    localparam int CTL_MODE      = 4;
    localparam int CTL_EN        = 5;
    localparam int CTL_CLR       = 6;
    localparam int CTL_MASK_WE   = 7;
    localparam int CTL_MASK_LSB  = 8;
    localparam int CTL_MASK_W    = 16;
    localparam int CTL_VIEW      = 31;
    localparam int RDATA_RUN_LSB = 16;

endpackage

// File: rtl/sr_timer_channel.sv
// One down-counter timer channel: reload register, one-shot/periodic mode, sticky expiry flag.
module sr_timer_channel
    import sr_timer_bank_pkg::*;
#(
    parameter int CNT_W = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             set_mode,
    input  mode_t            mode,
    input  logic             set_en,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             flag
);

    state_t           state, state_nxt;
    mode_t            mode_q, mode_eff;
    logic             en_q, en_eff, expire, flag_nxt;
    logic [CNT_W-1:0] reload, reload_nxt, count_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mode_q <= ONESHOT;
            en_q   <= 1'b0;
            count  <= '0;
            reload <= '0;
            flag   <= 1'b0;
        end else begin
            state  <= state_nxt;
            mode_q <= mode_eff;
            en_q   <= en_eff;
            count  <= count_nxt;
            reload <= reload_nxt;
            flag   <= flag_nxt;
        end
    end

    // A control write in the same cycle takes effect before the load/tick it accompanies.
    always_comb begin
        mode_eff   = set_mode ? mode : mode_q;
        en_eff     = set_en ? en : en_q;
        state_nxt  = state;
        count_nxt  = count;
        reload_nxt = reload;
        expire     = 1'b0;
        if (state == RUN && tick) begin
            if (count != '0) begin
                count_nxt = count - CNT_W'(1);
            end else begin
                expire = 1'b1;
                if (mode_eff == PERIODIC) count_nxt = reload;
                else                      state_nxt = DONE;
            end
        end
        if (load) begin
            reload_nxt = load_val;
            count_nxt  = load_val;
            if (en_eff) state_nxt = RUN;
        end
        if (set_en && !en) state_nxt = IDLE;
        // Expiry beats a simultaneous clear.
        flag_nxt = expire | (flag & ~clr);
    end

    assign running = (state == RUN);

endmodule

// File: rtl/sr_timer_bank.sv
// Bank of NCH programmable down-counter timers on the vcu register interface.
// Optional masked interrupt output enabled by defining TIMER_IRQ_EN.
module sr_timer_bank
    import sr_timer_bank_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int CNT_W     = 28,
    parameter int PRESC_DIV = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] reg_control,
    input  logic        reg_control_we,
    input  logic [31:0] reg_wdata,
    input  logic        reg_wdata_we,
    output logic [31:0] reg_rdata
`ifdef TIMER_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    logic [PW-1:0]               presc;
    logic                        tick;
    logic [CTL_SEL_W-1:0]        ctl_sel, sel_eff, sel_q;
    logic                        view_q;
    logic [NCH-1:0]              ctl_hit, load_hit, running, flags;
    logic [NCH-1:0][CNT_W-1:0]   counts;
    logic [CNT_W-1:0]            cnt_sel;
    logic                        unused_bits;

    assign unused_bits = ^{reg_control, reg_wdata};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            sel_q  <= '0;
            view_q <= 1'b0;
        end else begin
            presc <= (presc == PW'(PRESC_DIV - 1)) ? '0 : presc + PW'(1);
            if (reg_control_we) begin
                sel_q  <= ctl_sel;
                view_q <= reg_control[CTL_VIEW];
            end
        end
    end

    assign tick    = (presc == '0);
    assign ctl_sel = reg_control[CTL_SEL_LSB +: CTL_SEL_W];
    assign sel_eff = reg_control_we ? ctl_sel : sel_q;

    // Selects >= NCH match no instance, so out-of-range writes fall away naturally.
    for (genvar i = 0; i < NCH; i++) begin : g_ch
        assign ctl_hit[i]  = reg_control_we && (ctl_sel == CTL_SEL_W'(i));
        assign load_hit[i] = reg_wdata_we && (sel_eff == CTL_SEL_W'(i));

        sr_timer_channel #(.CNT_W(CNT_W)) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick),
            .load     (load_hit[i]),
            .load_val (reg_wdata[CNT_W-1:0]),
            .set_mode (ctl_hit[i]),
            .mode     (mode_t'(reg_control[CTL_MODE])),
            .set_en   (ctl_hit[i]),
            .en       (reg_control[CTL_EN]),
            .clr      (ctl_hit[i] & reg_control[CTL_CLR]),
            .count    (counts[i]),
            .running  (running[i]),
            .flag     (flags[i])
        );
    end

    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NCH; i++)
            if (sel_q == CTL_SEL_W'(i)) cnt_sel = counts[i];
        reg_rdata = '0;
        if (view_q) begin
            reg_rdata[CNT_W-1:0] = cnt_sel;
        end else begin
            reg_rdata[NCH-1:0]                = flags;
            reg_rdata[RDATA_RUN_LSB +: NCH]   = running;
        end
    end

`ifdef TIMER_IRQ_EN
    logic [NCH-1:0] irq_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_mask <= '0;
            irq      <= 1'b0;
        end else begin
            if (reg_control_we && reg_control[CTL_MASK_WE])
                irq_mask <= reg_control[CTL_MASK_LSB +: NCH];
            irq <= |(flags & irq_mask);
        end
    end
`endif

endmodule
